// File: rtl/approx_mac_pkg.sv
// Shared types, defaults and range helper for the approximate-multiplier MAC accumulator.
package approx_mac_pkg;

    typedef enum logic [0:0] {ACCUM, HOLD} mac_state_t;

    localparam int unsigned DEF_ACC_W = 24;
    localparam int unsigned DEF_LEN   = 8;
    localparam int unsigned PROD_W    = 16;

    // True when a sign-extended sum falls outside the signed acc_w-bit range.
    function automatic logic sat_range_check(input logic signed [32:0] sum, input int unsigned acc_w);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = 64'(sum);
        hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (acc_w - 1));
        return (s > hi) || (s < lo);
    endfunction

endpackage

// File: rtl/approx_log_mac_accum_sat_add.sv
// Combinational accumulate step: widened add, overflow detect, optional clamp to the signed range.
module sat_add_acc
    import approx_mac_pkg::*;
#(
    parameter int unsigned ACC_W    = DEF_ACC_W,
    parameter bit          SATURATE = 1'b1
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [PROD_W-1:0] prod,
    output logic signed [ACC_W-1:0]  result_c,
    output logic                     ovf_c
);

    localparam int unsigned SUM_W = ACC_W + 1;
    localparam logic signed [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [SUM_W-1:0] sum;
    logic signed [32:0]      sum_ext;

    always_comb begin
        sum      = SUM_W'(acc) + SUM_W'(prod);
        sum_ext  = 33'(sum);
        ovf_c    = sat_range_check(sum_ext, ACC_W);
        result_c = sum[ACC_W-1:0];
        // The sign of the widened sum tells which rail was crossed.
        if (ovf_c && SATURATE) begin
            result_c = sum[ACC_W] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/approx_log_mac_accum.sv
// Groups LEN signed products into one signed ACC_W-bit sum with a sticky overflow flag,
// handing each sum downstream over a valid/ready handshake.
module approx_log_mac_accum
    import approx_mac_pkg::*;
#(
    parameter int unsigned ACC_W    = DEF_ACC_W,
    parameter int unsigned LEN      = DEF_LEN,
    parameter bit          SATURATE = 1'b1,
    localparam int unsigned CNT_W   = $clog2(LEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     prod_valid,
    output logic                     prod_ready,
    input  logic signed [PROD_W-1:0] prod_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     out_ovf,
    output logic [CNT_W-1:0]         count
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    mac_state_t              state;
    mac_state_t              state_nxt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_nxt;
    logic signed [ACC_W-1:0] add_res;
    logic signed [ACC_W-1:0] out_data_nxt;
    logic [CNT_W-1:0]        count_nxt;
    logic                    ovf_sticky;
    logic                    ovf_sticky_nxt;
    logic                    add_ovf;
    logic                    out_valid_nxt;
    logic                    out_ovf_nxt;

    sat_add_acc #(
        .ACC_W    (ACC_W),
        .SATURATE (SATURATE)
    ) u_add (
        .acc      (acc),
        .prod     (prod_data),
        .result_c (add_res),
        .ovf_c    (add_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ACCUM;
            acc        <= '0;
            count      <= '0;
            ovf_sticky <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ovf    <= 1'b0;
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            count      <= count_nxt;
            ovf_sticky <= ovf_sticky_nxt;
            out_valid  <= out_valid_nxt;
            out_data   <= out_data_nxt;
            out_ovf    <= out_ovf_nxt;
        end
    end

    // Ready is a function of state and clear only, never of prod_valid.
    always_comb begin
        state_nxt      = state;
        acc_nxt        = acc;
        count_nxt      = count;
        ovf_sticky_nxt = ovf_sticky;
        out_valid_nxt  = out_valid;
        out_data_nxt   = out_data;
        out_ovf_nxt    = out_ovf;
        prod_ready     = 1'b0;

        case (state)
            ACCUM: begin
                prod_ready = !clear;
                if (clear) begin
                    acc_nxt        = '0;
                    count_nxt      = '0;
                    ovf_sticky_nxt = 1'b0;
                end else if (prod_valid) begin
                    if (count == LAST) begin
                        out_data_nxt   = add_res;
                        out_ovf_nxt    = ovf_sticky | add_ovf;
                        out_valid_nxt  = 1'b1;
                        acc_nxt        = '0;
                        count_nxt      = '0;
                        ovf_sticky_nxt = 1'b0;
                        state_nxt      = HOLD;
                    end else begin
                        acc_nxt        = add_res;
                        count_nxt      = count + CNT_W'(1);
                        ovf_sticky_nxt = ovf_sticky | add_ovf;
                    end
                end
            end
            HOLD: begin
                // clear is ignored here; the pending sum must be taken first.
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    state_nxt     = ACCUM;
                end
            end
            default: begin
                state_nxt = ACCUM;
            end
        endcase
    end

endmodule

// File: tb/tb_approx_log_mac_accum.sv
// Scoreboard bench: one saturating and one wrapping instance (ACC_W=16, LEN=4) share stimulus.
module tb_approx_log_mac_accum;

    localparam int unsigned ACC_W = 16;
    localparam int unsigned LEN   = 4;
    localparam int unsigned CNT_W = 3;

    typedef struct {
        longint s;
        longint w;
        bit     os;
        bit     ow;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    clear = 1'b0;
    logic                    prod_valid = 1'b0;
    logic                    out_ready = 1'b1;
    logic signed [15:0]      prod_data = '0;

    logic                    prod_ready_s, prod_ready_w;
    logic                    out_valid_s, out_valid_w;
    logic signed [ACC_W-1:0] out_data_s, out_data_w;
    logic                    out_ovf_s, out_ovf_w;
    logic [CNT_W-1:0]        count_s, count_w;

    approx_log_mac_accum #(.ACC_W(ACC_W), .LEN(LEN), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .prod_valid(prod_valid), .prod_ready(prod_ready_s), .prod_data(prod_data),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .out_ovf(out_ovf_s), .count(count_s)
    );

    approx_log_mac_accum #(.ACC_W(ACC_W), .LEN(LEN), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .prod_valid(prod_valid), .prod_ready(prod_ready_w), .prod_data(prod_data),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
        .out_ovf(out_ovf_w), .count(count_w)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   n_push = 0;
    int   n_pop = 0;
    bit   chk_en = 1'b0;
    bit   rand_done = 1'b0;
    exp_t q[$];

    // Reference state: current partial group and whether a sum is pending.
    bit     m_hold = 1'b0;
    int     m_cnt = 0;
    longint m_sat = 0;
    longint m_wrap = 0;
    bit     m_os = 1'b0;
    bit     m_ow = 1'b0;

    task automatic chk(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic model_reset_group();
        m_cnt  = 0;
        m_sat  = 0;
        m_wrap = 0;
        m_os   = 1'b0;
        m_ow   = 1'b0;
    endtask

    task automatic model_add(input longint d);
        longint s;
        longint w;
        exp_t   e;
        s = m_sat + d;
        if (s > 32767 || s < -32768) m_os = 1'b1;
        m_sat = (s > 32767) ? 32767 : (s < -32768) ? -32768 : s;
        w = m_wrap + d;
        if (w > 32767 || w < -32768) m_ow = 1'b1;
        if (w > 32767) w = w - 65536;
        else if (w < -32768) w = w + 65536;
        m_wrap = w;
        m_cnt++;
        if (m_cnt == LEN) begin
            e.s = m_sat; e.w = m_wrap; e.os = m_os; e.ow = m_ow;
            q.push_back(e);
            n_push++;
            model_reset_group();
            m_hold = 1'b1;
        end
    endtask

    // Reference model, advanced on every rising edge from the bench's own inputs.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                model_reset_group();
                m_hold = 1'b0;
                q.delete();
            end else if (m_hold) begin
                if (out_ready) m_hold = 1'b0;
            end else if (clear) begin
                model_reset_group();
            end else if (prod_valid) begin
                model_add(longint'(prod_data));
            end
        end
    end

    // Handshake/counter checker, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("prod_ready_sat", prod_ready_s, longint'(!m_hold && !clear));
                chk("prod_ready_wrap", prod_ready_w, longint'(!m_hold && !clear));
                chk("out_valid_sat", out_valid_s, longint'(m_hold));
                chk("out_valid_wrap", out_valid_w, longint'(m_hold));
                chk("count_sat", count_s, longint'(m_cnt));
                chk("count_wrap", count_w, longint'(m_cnt));
            end
        end
    end

    // Monitor: pops an expected sum whenever the DUT hands one over.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_en && rst_n && out_valid_s && out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty: got output %0d expected none", out_data_s);
                end else begin
                    e = q.pop_front();
                    n_pop++;
                    chk("sb_data_sat", out_data_s, e.s);
                    chk("sb_data_wrap", out_data_w, e.w);
                    chk("sb_ovf_sat", out_ovf_s, longint'(e.os));
                    chk("sb_ovf_wrap", out_ovf_w, longint'(e.ow));
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic signed [15:0] d);
        bit ok;
        ok = 1'b0;
        prod_valid = 1'b1;
        prod_data  = d;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (prod_ready_s) ok = 1'b1;
        end
        sync();
        prod_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL push_timeout: prod_ready low for 200 cycles, required high");
        end
    endtask

    task automatic expect_out(input string tag, input longint es, input longint ew,
                              input bit os, input bit ow, input int max_wait);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid_s && n < max_wait) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, out_valid_s, 1);
        chk({tag, "_data_sat"}, out_data_s, es);
        chk({tag, "_data_wrap"}, out_data_w, ew);
        chk({tag, "_ovf_sat"}, out_ovf_s, longint'(os));
        chk({tag, "_ovf_wrap"}, out_ovf_w, longint'(ow));
    endtask

    function automatic logic signed [15:0] rand_data();
        int r;
        r = int'($urandom_range(0, 2));
        if (r == 0) return 16'($urandom);
        if (r == 1) return 16'(int'($urandom_range(0, 200)) - 100);
        return ($urandom_range(0, 1) != 0) ? 16'h7fff : 16'h8000;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_out_data", out_data_s, 0);
        chk("rst_out_ovf", out_ovf_s, 0);
        chk("rst_count", count_s, 0);
        chk("rst_out_valid", out_valid_s, 0);
        chk("rst_prod_ready", prod_ready_s, 1);
        sync();

        // Reset in the middle of a group discards the partial sum.
        push(100); push(200); push(300);
        rst_n = 1'b0;
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_count", count_s, 0);
        chk("midrst_valid", out_valid_s, 0);
        chk("midrst_ready", prod_ready_s, 1);
        sync();
        push(1); push(2); push(3); push(4);
        expect_out("midrst", 10, 10, 0, 0, 2);
        sync();

        // Basic group: result one cycle after the last accept, ready right after the transfer.
        push(16384); push(-16384); push(127); push(-1);
        expect_out("basic", 126, 126, 0, 0, 0);
        @(negedge clk);
        chk("basic_ready_after", prod_ready_s, 1);
        sync();

        // Downstream stall holds the sum and consumes nothing.
        out_ready = 1'b0;
        push(1); push(2); push(3); push(4);
        expect_out("bp", 10, 10, 0, 0, 2);
        sync();
        prod_valid = 1'b1;
        prod_data  = 16'sd99;
        repeat (10) begin
            @(negedge clk);
            chk("bp_hold_valid", out_valid_s, 1);
            chk("bp_hold_ready", prod_ready_s, 0);
            chk("bp_hold_data", out_data_s, 10);
            chk("bp_hold_count", count_s, 0);
        end
        sync();
        prod_valid = 1'b0;
        out_ready  = 1'b1;
        sync();
        @(negedge clk);
        chk("bp_done_valid", out_valid_s, 0);
        sync();

        // Overflow: clamp vs wrap, sticky flag cleared per group.
        push(16384); push(16384); push(0); push(0);
        expect_out("ovf1", 32767, -32768, 1, 1, 2);
        sync();
        push(1); push(1); push(0); push(0);
        expect_out("ovf_clr", 2, 2, 0, 0, 2);
        sync();
        push(32767); push(1); push(-2); push(0);
        expect_out("ovf2", 32765, 32766, 1, 1, 2);
        sync();

        // clear drops the partial group and refuses the coincident product.
        push(5); push(6);
        clear      = 1'b1;
        prod_valid = 1'b1;
        prod_data  = 16'sd7;
        @(negedge clk);
        chk("clr_ready", prod_ready_s, 0);
        sync();
        clear      = 1'b0;
        prod_valid = 1'b0;
        @(negedge clk);
        chk("clr_count", count_s, 0);
        sync();
        push(1); push(1); push(1); push(1);
        expect_out("clr", 4, 4, 0, 0, 2);
        sync();

        // clear in HOLD leaves the pending sum untouched.
        out_ready = 1'b0;
        push(1); push(2); push(3); push(4);
        expect_out("hclr", 10, 10, 0, 0, 2);
        sync();
        clear = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("hclr_data", out_data_s, 10);
            chk("hclr_valid", out_valid_s, 1);
        end
        sync();
        clear     = 1'b0;
        out_ready = 1'b1;
        sync();

        // Random traffic with random back-pressure.
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        repeat ($urandom_range(1, 3)) sync();
                    end
                    push(rand_data());
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    sync();
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        for (int i = 0; i < 100 && (q.size() != 0 || out_valid_s); i++) sync();
        repeat (2) sync();
        chk("drain_queue", longint'(q.size()), 0);
        chk("group_count", n_pop, n_push);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
